// File: rtl/mem_arbiter.sv
module mem_arbiter #(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned MAX_LS_STREAK = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned          STREAK_W   = $clog2(MAX_LS_STREAK + 1);
  localparam logic [STREAK_W-1:0]  STREAK_MAX = STREAK_W'(MAX_LS_STREAK);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_LS
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [STREAK_W-1:0] streak;
  logic                squash;
  logic                grant_ls;
  logic                grant_if;

  always_comb begin
    grant_ls = 1'b0;
    grant_if = 1'b0;
    if (state == IDLE) begin
      if (ls_req && !(if_req && (streak == STREAK_MAX))) begin
        grant_ls = 1'b1;
      end else if (if_req && !if_flush) begin
        grant_if = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant_ls) begin
          state_next = BUSY_LS;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end
      end
      BUSY_IF, BUSY_LS: begin
        if (mem_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state != IDLE);
    ls_ack   = mem_ack && (state == BUSY_LS);
    if_ack   = mem_ack && (state == BUSY_IF) && !squash && !if_flush;
    ls_rdata = mem_rdata;
    if_rdata = mem_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else if (grant_ls) begin
      mem_we    <= ls_we;
      mem_addr  <= ls_addr;
      mem_wdata <= ls_wdata;
    end else if (grant_if) begin
      mem_we    <= 1'b0;
      mem_addr  <= if_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak <= '0;
    end else if (grant_ls) begin
      if (!if_req) begin
        streak <= '0;
      end else if (streak != STREAK_MAX) begin
        streak <= streak + STREAK_W'(1);
      end
    end else if (grant_if) begin
      streak <= '0;
    end
  end

  // Clearing on completion takes priority so a flush in the ack cycle cannot leak into the next transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      squash <= 1'b0;
    end else if ((state != IDLE) && mem_ack) begin
      squash <= 1'b0;
    end else if (((state == BUSY_IF) || grant_if) && if_flush) begin
      squash <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_flush;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic        ls_we;
  logic [31:0] ls_addr;
  logic [31:0] ls_wdata;
  logic        ls_ack;
  logic [31:0] ls_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad   = 0;

  mem_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .MAX_LS_STREAK(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .if_addr(if_addr),
    .if_flush(if_flush),
    .if_ack(if_ack),
    .if_rdata(if_rdata),
    .ls_req(ls_req),
    .ls_we(ls_we),
    .ls_addr(ls_addr),
    .ls_wdata(ls_wdata),
    .ls_ack(ls_ack),
    .ls_rdata(ls_rdata),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        ireq;
    logic [31:0] iaddr;
    logic        iflush;
    logic        lreq;
    logic        lwe;
    logic [31:0] laddr;
    logic [31:0] lwdata;
    logic        mack;
    logic [31:0] mrdata;
    logic        e_req;
    logic        e_we;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic        e_iack;
    logic        e_lack;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic [31:0] rst, input logic [31:0] ireq, input logic [31:0] iaddr, input logic [31:0] iflush,
    input logic [31:0] lreq, input logic [31:0] lwe, input logic [31:0] laddr, input logic [31:0] lwdata,
    input logic [31:0] mack, input logic [31:0] mrdata,
    input logic [31:0] e_req, input logic [31:0] e_we, input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [31:0] e_iack, input logic [31:0] e_lack);
    vec_t v;
    v.rst     = rst[0];
    v.ireq    = ireq[0];
    v.iaddr   = iaddr;
    v.iflush  = iflush[0];
    v.lreq    = lreq[0];
    v.lwe     = lwe[0];
    v.laddr   = laddr;
    v.lwdata  = lwdata;
    v.mack    = mack[0];
    v.mrdata  = mrdata;
    v.e_req   = e_req[0];
    v.e_we    = e_we[0];
    v.e_addr  = e_addr;
    v.e_wdata = e_wdata;
    v.e_iack  = e_iack[0];
    v.e_lack  = e_lack[0];
    return v;
  endfunction

  task automatic check1(input string name, input int idx, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%b want=%b", name, idx, act, exp);
    end
  endtask

  task automatic check32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%h want=%h", name, idx, act, exp);
    end
  endtask

  initial begin
    int unsigned cnt;
    int unsigned w;
    logic        exp_if;

    reset = 1'b1; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
    ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);

    // rst ireq iaddr iflush lreq lwe laddr lwdata mack mrdata | req we addr wdata iack lack
    // reset state, IF-only read
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,             0,0,0,0,0,0));
    vq.push_back(mk(0,1,'h100,0, 0,0,0,0, 0,0,         0,0,0,0,0,0));
    vq.push_back(mk(0,1,'h100,0, 0,0,0,0, 0,0,         1,0,'h100,0,0,0));
    vq.push_back(mk(0,1,'h100,0, 0,0,0,0, 0,0,         1,0,'h100,0,0,0));
    vq.push_back(mk(0,1,'h100,0, 0,0,0,0, 1,'hCAFE0001, 1,0,'h100,0,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,             0,0,'h100,0,0,0));
    // simultaneous: LS write wins, then IF
    vq.push_back(mk(0,1,'h300,0, 1,1,'h200,'hDEADBEEF, 0,0,    0,0,'h100,0,0,0));
    vq.push_back(mk(0,1,'h300,0, 1,1,'h200,'hDEADBEEF, 0,0,    1,1,'h200,'hDEADBEEF,0,0));
    vq.push_back(mk(0,1,'h300,0, 1,1,'h200,'hDEADBEEF, 1,'h11, 1,1,'h200,'hDEADBEEF,0,1));
    vq.push_back(mk(0,1,'h300,0, 0,0,0,0, 0,0,                 0,1,'h200,'hDEADBEEF,0,0));
    vq.push_back(mk(0,1,'h300,0, 0,0,0,0, 1,'h22,              1,0,'h300,'hDEADBEEF,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                     0,0,'h300,'hDEADBEEF,0,0));
    // starvation: LS x4, IF, LS
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h300,'hDEADBEEF,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h31,  1,0,'h400,'h55,0,1));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h400,'h55,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h31,  1,0,'h400,'h55,0,1));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h400,'h55,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h31,  1,0,'h400,'h55,0,1));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h400,'h55,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h31,  1,0,'h400,'h55,0,1));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h400,'h55,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h32,  1,0,'h500,'h55,1,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 0,0,     0,0,'h500,'h55,0,0));
    vq.push_back(mk(0,1,'h500,0, 1,0,'h400,'h55, 1,'h33,  1,0,'h400,'h55,0,1));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                0,0,'h400,'h55,0,0));
    // flush after IF grant squashes the ack; next IF request is normal
    vq.push_back(mk(0,1,'h600,0, 0,0,0,0, 0,0,            0,0,'h400,'h55,0,0));
    vq.push_back(mk(0,1,'h600,1, 0,0,0,0, 0,0,            1,0,'h600,'h55,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                1,0,'h600,'h55,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,'h77,             1,0,'h600,'h55,0,0));
    vq.push_back(mk(0,1,'h700,0, 0,0,0,0, 0,0,            0,0,'h600,'h55,0,0));
    vq.push_back(mk(0,1,'h700,0, 0,0,0,0, 1,'h88,         1,0,'h700,'h55,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                0,0,'h700,'h55,0,0));
    // flush in IDLE blocks the IF grant for that cycle
    vq.push_back(mk(0,1,'h800,1, 0,0,0,0, 0,0,            0,0,'h700,'h55,0,0));
    vq.push_back(mk(0,1,'h800,0, 0,0,0,0, 0,0,            0,0,'h700,'h55,0,0));
    vq.push_back(mk(0,1,'h800,0, 0,0,0,0, 1,'h99,         1,0,'h800,'h55,1,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                0,0,'h800,'h55,0,0));
    // reset in BUSY_LS, then stray acks in IDLE
    vq.push_back(mk(0,0,0,0, 1,1,'h900,'h12345678, 0,0,   0,0,'h800,'h55,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h900,'h12345678, 0,0,   1,1,'h900,'h12345678,0,0));
    vq.push_back(mk(1,0,0,0, 1,1,'h900,'h12345678, 0,0,   1,1,'h900,'h12345678,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,'hAA,             0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 1,'hBB,             0,0,0,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                0,0,0,0,0,0));
    // flush coinciding with the memory ack
    vq.push_back(mk(0,1,'hA00,0, 0,0,0,0, 0,0,            0,0,0,0,0,0));
    vq.push_back(mk(0,1,'hA00,1, 0,0,0,0, 1,'hCC,         1,0,'hA00,0,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,                0,0,'hA00,0,0,0));

    foreach (vq[i]) begin
      @(negedge clk);
      reset = vq[i].rst; if_req = vq[i].ireq; if_addr = vq[i].iaddr; if_flush = vq[i].iflush;
      ls_req = vq[i].lreq; ls_we = vq[i].lwe; ls_addr = vq[i].laddr; ls_wdata = vq[i].lwdata;
      mem_ack = vq[i].mack; mem_rdata = vq[i].mrdata;
      #1;
      check1("mem_req", i, mem_req, vq[i].e_req);
      check1("mem_we", i, mem_we, vq[i].e_we);
      check32("mem_addr", i, mem_addr, vq[i].e_addr);
      check32("mem_wdata", i, mem_wdata, vq[i].e_wdata);
      check1("if_ack", i, if_ack, vq[i].e_iack);
      check1("ls_ack", i, ls_ack, vq[i].e_lack);
      if (vq[i].e_iack) check32("if_rdata", i, if_rdata, vq[i].mrdata);
      if (vq[i].e_lack) check32("ls_rdata", i, ls_rdata, vq[i].mrdata);
    end

    // Both requesters held continuously: grant order LS,LS,LS,LS,IF repeating.
    @(negedge clk);
    reset = 1'b0; if_flush = 1'b0; mem_ack = 1'b0;
    if_req = 1'b1; if_addr = 32'h500;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; ls_wdata = 32'h55;
    cnt = 0;
    for (int t = 0; t < 10; t++) begin
      w = 0;
      #1;
      while (!mem_req && w < 8) begin
        @(negedge clk);
        #1;
        w++;
      end
      check1("seq_req_seen", t, mem_req, 1'b1);
      exp_if = (cnt == 4);
      cnt = exp_if ? 0 : cnt + 1;
      mem_ack = 1'b1;
      mem_rdata = 32'h1000 + t;
      #1;
      check1("seq_if_ack", t, if_ack, exp_if);
      check1("seq_ls_ack", t, ls_ack, !exp_if);
      check32("seq_addr", t, mem_addr, exp_if ? 32'h500 : 32'h400);
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      @(negedge clk);
    end
    if_req = 1'b0;
    ls_req = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
